// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the MEM-stage AXI4-Lite user bridge.
// Holds the bridge state encoding, response codes and default widths.
package axi_bridge_pkg;

   localparam int ADDR_W_DFLT = 32;
   localparam int DATA_W_DFLT = 32;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_DONE
   } state_t;

   // The bridge takes a new request only when nothing is in flight.
   function automatic logic is_accepting(input state_t s);
      return (s == ST_IDLE) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/axi_user_bridge.sv
// Responder for the MEM-stage user load/store interface; turns each request
// into a single AXI4-Lite read (AR/R) or write (AW/W/B), one at a time.
module axi_user_bridge
   import axi_bridge_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int DATA_W = DATA_W_DFLT
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                axi_start,
   input  logic                axi_rw,
   input  logic [ADDR_W-1:0]   axi_addr,
   input  logic [DATA_W-1:0]   axi_wdata,
   input  logic                axi_wvalid,
   output logic                axi_wready,
   output logic [DATA_W-1:0]   axi_rdata,
   output logic                axi_done,
   output logic                axi_busy,
   output logic                axi_err,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rvalid,
   output logic                m_rready,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready
);

   state_t state;
   logic   accepting;
   logic   aw_ok;
   logic   w_ok;
   logic   aw_hs;
   logic   w_hs;

   // Store data is captured with axi_start, so the valid hint carries no extra information.
   logic   unused_wvalid;
   assign unused_wvalid = axi_wvalid;

   assign accepting  = is_accepting(state);
   assign axi_wready = accepting;
   assign axi_busy   = !accepting;
   assign m_wstrb    = '1;
   assign aw_hs      = m_awvalid && m_awready;
   assign w_hs       = m_wvalid && m_wready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         m_arvalid <= 1'b0;
         m_rready  <= 1'b0;
         m_awvalid <= 1'b0;
         m_wvalid  <= 1'b0;
         m_bready  <= 1'b0;
         axi_done  <= 1'b0;
         axi_err   <= 1'b0;
         axi_rdata <= '0;
         m_araddr  <= '0;
         m_awaddr  <= '0;
         m_wdata   <= '0;
         aw_ok     <= 1'b0;
         w_ok      <= 1'b0;
      end else begin
         // done and err are only ever visible during the single DONE cycle
         axi_done <= 1'b0;
         axi_err  <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               state <= ST_IDLE;
               if (axi_start) begin
                  if (axi_rw) begin
                     m_araddr  <= axi_addr;
                     m_arvalid <= 1'b1;
                     state     <= ST_RD_ADDR;
                  end else begin
                     m_awaddr  <= axi_addr;
                     m_wdata   <= axi_wdata;
                     m_awvalid <= 1'b1;
                     m_wvalid  <= 1'b1;
                     aw_ok     <= 1'b0;
                     w_ok      <= 1'b0;
                     state     <= ST_WR_REQ;
                  end
               end
            end
            ST_RD_ADDR: begin
               if (m_arready) begin
                  m_arvalid <= 1'b0;
                  m_rready  <= 1'b1;
                  state     <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (m_rvalid) begin
                  axi_rdata <= m_rdata;
                  axi_err   <= (m_rresp != RESP_OKAY);
                  m_rready  <= 1'b0;
                  axi_done  <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_WR_REQ: begin
               // AW and W complete independently, in either order or together
               if (aw_hs) begin
                  m_awvalid <= 1'b0;
                  aw_ok     <= 1'b1;
               end
               if (w_hs) begin
                  m_wvalid <= 1'b0;
                  w_ok     <= 1'b1;
               end
               if ((aw_ok || aw_hs) && (w_ok || w_hs)) begin
                  m_bready <= 1'b1;
                  state    <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (m_bvalid) begin
                  axi_err  <= (m_bresp != RESP_OKAY);
                  m_bready <= 1'b0;
                  axi_done <= 1'b1;
                  state    <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_user_bridge.sv
// Directed bench for axi_user_bridge: delay-configurable AXI4-Lite slave, a
// transaction-level expectation model checked every cycle, plus literal checks.
module tb_axi_user_bridge;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            resetn = 1'b0;
   logic            axi_start = 1'b0;
   logic            axi_rw = 1'b0;
   logic [AW-1:0]   axi_addr = '0;
   logic [DW-1:0]   axi_wdata = '0;
   logic            axi_wvalid = 1'b0;
   logic            axi_wready;
   logic [DW-1:0]   axi_rdata;
   logic            axi_done, axi_busy, axi_err;
   logic [AW-1:0]   m_araddr, m_awaddr;
   logic            m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_wstrb;
   logic            m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp, m_bresp;

   axi_user_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .resetn(resetn),
      .axi_start(axi_start), .axi_rw(axi_rw), .axi_addr(axi_addr),
      .axi_wdata(axi_wdata), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_rdata(axi_rdata), .axi_done(axi_done), .axi_busy(axi_busy), .axi_err(axi_err),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Slave settings: cycles of wait before ready / response
   int            ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
   logic [DW-1:0] rd_val = '0;
   logic [1:0]    rr_val = 2'b00, br_val = 2'b00;

   // Behavioural slave: drives its outputs just after each negedge
   initial begin
      int   ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
      logic r_pend, b_pend, aw_seen, w_seen;
      logic p_arvalid, p_rready, p_awvalid, p_wvalid, p_bready;
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
      p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0; p_bready = 0;
      m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      m_rdata = '0; m_rresp = 2'b00; m_bresp = 2'b00;
      forever begin
         @(negedge clk);
         #1;
         if (!resetn) begin
            m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
            ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
            r_pend = 0; b_pend = 0; aw_seen = 0; w_seen = 0;
            p_arvalid = 0; p_rready = 0; p_awvalid = 0; p_wvalid = 0; p_bready = 0;
         end else begin
            if (p_arvalid && m_arready) begin r_pend = 1; r_cnt = 0; end
            if (m_rvalid && p_rready) begin m_rvalid = 0; m_rdata = '0; end
            if (p_awvalid && m_awready) aw_seen = 1;
            if (p_wvalid && m_wready) w_seen = 1;
            if (m_bvalid && p_bready) m_bvalid = 0;
            if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
            if (r_pend) begin
               if (r_cnt >= r_dly) begin
                  m_rvalid = 1; m_rdata = rd_val; m_rresp = rr_val; r_pend = 0;
               end else r_cnt++;
            end
            if (b_pend) begin
               if (b_cnt >= b_dly) begin
                  m_bvalid = 1; m_bresp = br_val; b_pend = 0;
               end else b_cnt++;
            end
            if (m_arvalid) begin m_arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin m_arready = 0; ar_cnt = 0; end
            if (m_awvalid) begin m_awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin m_awready = 0; aw_cnt = 0; end
            if (m_wvalid) begin m_wready = (w_cnt >= w_dly); w_cnt++; end
            else begin m_wready = 0; w_cnt = 0; end
            p_arvalid = m_arvalid; p_rready = m_rready; p_awvalid = m_awvalid;
            p_wvalid = m_wvalid; p_bready = m_bready;
         end
      end
   end

   // Transaction-level expectation: one outstanding request, finished by its response handshake
   logic          started = 0;
   logic          e_out = 0, e_load = 0, e_done = 0, e_err = 0;
   logic [AW-1:0] e_addr = '0;
   logic [DW-1:0] e_wdata = '0, e_rdata = '0;
   logic          e_ar_done = 0, e_aw_done = 0, e_w_done = 0;
   logic          pend_ar = 0, pend_aw = 0, pend_w = 0, hs_ar = 0, hs_aw = 0, hs_w = 0;

   always @(posedge clk) begin
      started <= 1'b1;
      pend_ar <= resetn && m_arvalid && !m_arready;
      pend_aw <= resetn && m_awvalid && !m_awready;
      pend_w  <= resetn && m_wvalid && !m_wready;
      hs_ar   <= resetn && m_arvalid && m_arready;
      hs_aw   <= resetn && m_awvalid && m_awready;
      hs_w    <= resetn && m_wvalid && m_wready;
      if (!resetn) begin
         e_out <= 0; e_done <= 0; e_err <= 0; e_rdata <= '0;
         e_ar_done <= 0; e_aw_done <= 0; e_w_done <= 0;
      end else begin
         e_done <= 0;
         e_err  <= 0;
         if (e_out && e_load && m_arvalid && m_arready) e_ar_done <= 1;
         if (e_out && !e_load && m_awvalid && m_awready) e_aw_done <= 1;
         if (e_out && !e_load && m_wvalid && m_wready) e_w_done <= 1;
         if (e_out && e_load && m_rvalid && m_rready) begin
            e_out <= 0; e_done <= 1; e_err <= (m_rresp != 2'b00); e_rdata <= m_rdata;
         end else if (e_out && !e_load && m_bvalid && m_bready) begin
            e_out <= 0; e_done <= 1; e_err <= (m_bresp != 2'b00);
         end else if (!e_out && axi_start) begin
            e_out <= 1; e_load <= axi_rw; e_addr <= axi_addr; e_wdata <= axi_wdata;
            e_ar_done <= 0; e_aw_done <= 0; e_w_done <= 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("done", axi_done, e_done);
            chk("err", axi_err, e_err);
            chk("rdata", axi_rdata, e_rdata);
            chk("busy", axi_busy, e_out);
            chk("wready", axi_wready, !e_out);
            chk("wstrb", m_wstrb, 4'hF);
            if (!e_out || !e_load) begin
               chk("arvalid_quiet", m_arvalid, 0);
               chk("rready_quiet", m_rready, 0);
            end
            if (!e_out || e_load) begin
               chk("awvalid_quiet", m_awvalid, 0);
               chk("wvalid_quiet", m_wvalid, 0);
               chk("bready_quiet", m_bready, 0);
            end
            if (m_arvalid) chk("araddr", m_araddr, e_addr);
            if (m_awvalid) chk("awaddr", m_awaddr, e_addr);
            if (m_wvalid) chk("wdata", m_wdata, e_wdata);
            if (pend_ar) chk("arvalid_hold", m_arvalid, 1);
            if (pend_aw) chk("awvalid_hold", m_awvalid, 1);
            if (pend_w) chk("wvalid_hold", m_wvalid, 1);
            if (hs_ar || (e_out && e_load && e_ar_done)) chk("arvalid_drop", m_arvalid, 0);
            if (hs_aw || (e_out && !e_load && e_aw_done)) chk("awvalid_drop", m_awvalid, 0);
            if (hs_w || (e_out && !e_load && e_w_done)) chk("wvalid_drop", m_wvalid, 0);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called at a negedge (cycle T); returns at the negedge of T+1
   task automatic start_req(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
      axi_start = 1; axi_rw = rw; axi_addr = a; axi_wdata = d; axi_wvalid = !rw;
      @(negedge clk);
      axi_start = 0; axi_wvalid = 0;
   endtask

   initial begin
      int   n_done;
      logic seen_3000;
      cyc(3);
      chk("rst_busy", axi_busy, 0);
      chk("rst_wready", axi_wready, 1);
      chk("rst_done", axi_done, 0);
      chk("rst_err", axi_err, 0);
      chk("rst_rdata", axi_rdata, 0);
      chk("rst_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
      chk("rst_addrs", {m_araddr, m_awaddr}, 0);
      chk("rst_wdata", m_wdata, 0);
      chk("rst_wstrb", m_wstrb, 4'hF);
      resetn = 1;
      cyc(2);

      // Load, slave always ready
      rd_val = 32'hDEAD_BEEF;
      start_req(1, 32'h0000_1000, '0);
      chk("ld_arvalid_T1", m_arvalid, 1);
      chk("ld_araddr_T1", m_araddr, 32'h1000);
      chk("ld_busy_T1", axi_busy, 1);
      cyc(1);
      chk("ld_busy_T2", axi_busy, 1);
      chk("ld_rready_T2", m_rready, 1);
      cyc(1);
      chk("ld_done_T3", axi_done, 1);
      chk("ld_rdata_T3", axi_rdata, 32'hDEAD_BEEF);
      chk("ld_err_T3", axi_err, 0);
      chk("ld_busy_T3", axi_busy, 0);
      cyc(1);
      chk("ld_done_T4", axi_done, 0);
      cyc(1);

      // Store, AW ready at once, W ready three cycles later
      aw_dly = 0; w_dly = 3; b_dly = 1;
      start_req(0, 32'h0000_2004, 32'h1234_5678);
      chk("st_awvalid_T1", m_awvalid, 1);
      chk("st_wvalid_T1", m_wvalid, 1);
      chk("st_awaddr_T1", m_awaddr, 32'h2004);
      cyc(1);
      chk("st_awvalid_T2", m_awvalid, 0);
      chk("st_wvalid_T2", m_wvalid, 1);
      cyc(2);
      chk("st_wvalid_T4", m_wvalid, 1);
      chk("st_wdata_T4", m_wdata, 32'h1234_5678);
      cyc(1);
      chk("st_wvalid_T5", m_wvalid, 0);
      chk("st_bready_T5", m_bready, 1);
      chk("st_done_T5", axi_done, 0);
      cyc(1);
      chk("st_done_T6", axi_done, 0);
      cyc(1);
      chk("st_done_T7", axi_done, 1);
      chk("st_err_T7", axi_err, 0);
      chk("st_rdata_kept", axi_rdata, 32'hDEAD_BEEF);
      w_dly = 0; b_dly = 0;
      cyc(2);

      // Read error, then an OKAY read
      rd_val = 32'hCAFE_F00D; rr_val = 2'b10;
      start_req(1, 32'h0000_0040, '0);
      cyc(2);
      chk("rderr_done", axi_done, 1);
      chk("rderr_err", axi_err, 1);
      chk("rderr_rdata", axi_rdata, 32'hCAFE_F00D);
      cyc(1);
      chk("rderr_done_off", axi_done, 0);
      chk("rderr_err_off", axi_err, 0);
      rd_val = 32'h0BAD_F00D; rr_val = 2'b00;
      start_req(1, 32'h0000_0044, '0);
      cyc(2);
      chk("rdok_done", axi_done, 1);
      chk("rdok_err", axi_err, 0);
      chk("rdok_rdata", axi_rdata, 32'h0BAD_F00D);
      cyc(2);

      // Start while busy is dropped
      r_dly = 3; rd_val = 32'h1111_2222;
      start_req(1, 32'h0000_0500, '0);
      cyc(1);
      start_req(1, 32'h0000_3000, '0);
      n_done = 0; seen_3000 = 0;
      for (int i = 0; i < 9; i++) begin
         if (axi_done) n_done++;
         if (m_araddr == 32'h3000) seen_3000 = 1;
         cyc(1);
      end
      chk("busy_start_done_count", n_done, 1);
      chk("busy_start_no_3000", seen_3000, 0);
      chk("busy_start_rdata", axi_rdata, 32'h1111_2222);
      r_dly = 0;

      // Back-to-back load accepted in the DONE cycle
      rd_val = 32'h55AA_55AA;
      start_req(1, 32'h0000_0600, '0);
      cyc(1);
      rd_val = 32'h6677_8899;
      cyc(1);
      chk("b2b_done_first", axi_done, 1);
      start_req(1, 32'h0000_0604, '0);
      chk("b2b_arvalid", m_arvalid, 1);
      chk("b2b_araddr", m_araddr, 32'h604);
      chk("b2b_busy", axi_busy, 1);
      cyc(2);
      chk("b2b_done_second", axi_done, 1);
      chk("b2b_rdata", axi_rdata, 32'h6677_8899);
      cyc(2);

      // Reset during WR_REQ
      aw_dly = 5; w_dly = 5;
      start_req(0, 32'h0000_7000, 32'hA5A5_A5A5);
      chk("rstmid_awvalid_T1", m_awvalid, 1);
      cyc(1);
      resetn = 0;
      cyc(1);
      resetn = 1;
      chk("rstmid_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
      chk("rstmid_busy", axi_busy, 0);
      chk("rstmid_wready", axi_wready, 1);
      chk("rstmid_done", axi_done, 0);
      chk("rstmid_rdata", axi_rdata, 0);
      n_done = 0;
      for (int i = 0; i < 4; i++) begin
         if (axi_done) n_done++;
         cyc(1);
      end
      chk("rstmid_no_done", n_done, 0);
      aw_dly = 0; w_dly = 0;
      rd_val = 32'h0F0F_1234;
      start_req(1, 32'h0000_0800, '0);
      cyc(2);
      chk("rstmid_recover_done", axi_done, 1);
      chk("rstmid_recover_rdata", axi_rdata, 32'h0F0F_1234);
      cyc(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
